laser_search_sched: RTL and testbench
=====================================

Name: laser_search_sched

Overview:
- Sequencing controller for the LASER two-circle coverage search.
- Runs an alternating sweep. It holds one circle centre fixed, sweeps the other over all 256 grid candidates, and keeps the best. It then swaps roles and repeats until a full round brings no improvement or a round limit is reached.
- Union coverage counts (radius^2 <= 16 over the 40 buffered points) come from an external coverage evaluator through a req/ack handshake.
- Sits between the point-load front end (which pulses START) and the top-level C1/C2/DONE outputs.

Parameters:
- NUM_PTS, 40: points per image; sizes the count width.
- COORD_W, 4: coordinate width (16x16 grid).
- CNT_W, 6: coverage count width.
- MAX_ROUNDS, 8: round limit (one round = C1 sweep + C2 sweep).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse: point buffer loaded, begin search.
- EV_REQ  out  1  evaluation request.
- EV_SEL  out  1  0 = sweeping C1 (C2 fixed); 1 = sweeping C2 (C1 fixed).
- EV_CX  out  COORD_W  candidate X.
- EV_CY  out  COORD_W  candidate Y.
- EV_FX  out  COORD_W  fixed-centre X.
- EV_FY  out  COORD_W  fixed-centre Y.
- EV_ACK  in  1  evaluation complete; EV_CNT is valid this cycle.
- EV_CNT  in  CNT_W  union coverage of (candidate, fixed).
- C1X  out  COORD_W  committed circle-1 X.
- C1Y  out  COORD_W  committed circle-1 Y.
- C2X  out  COORD_W  committed circle-2 X.
- C2Y  out  COORD_W  committed circle-2 Y.
- DONE  out  1  one-cycle pulse: result valid.
- BUSY  out  1  high from the cycle after START until the DONE cycle, inclusive.
- ROUNDS  out  4  completed rounds, saturating at MAX_ROUNDS.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE.
  - All outputs 0: C1/C2, EV_* outputs, DONE, BUSY, ROUNDS.
  - Shadow best registers cleared.
- States: IDLE, INIT, REQ, NEXT, SWEEP_END, FIN.
- IDLE:
  - START=1 -> INIT.
  - C1/C2 outputs hold their last values.
- INIT (1 cycle):
  - C1 := (4,4), C2 := (11,11), best := 0, round_best := 0, ROUNDS := 0, sel := 0, candidate := (0,0).
  - Next state: REQ.
- REQ:
  - EV_REQ=1. EV_CX/EV_CY/EV_SEL/EV_FX/EV_FY stay stable until EV_ACK=1.
  - EV_FX/EV_FY = committed centre of the non-swept circle.
  - On ack: if EV_CNT > best (unsigned, strict), then best := EV_CNT and shadow := candidate. Ties keep the earlier candidate. Then go to NEXT.
- NEXT (1 cycle, EV_REQ=0):
  - Candidate advances in raster order: X increments first; on X=15 it wraps to 0 and Y increments.
  - Candidate (15,15) just evaluated -> SWEEP_END; otherwise -> REQ.
- SWEEP_END (1 cycle):
  - If the shadow was updated during this sweep, commit it to the swept circle (C1 if sel=0, else C2).
  - Toggle sel; candidate := (0,0).
  - If sel was 1 (round complete):
    - ROUNDS++ (saturating).
    - If best == round_best, or ROUNDS reaches MAX_ROUNDS -> FIN.
    - Otherwise round_best := best, then -> REQ.
  - If sel was 0 -> REQ.
- FIN (1 cycle): DONE=1, BUSY=1 -> IDLE. DONE is 0 in every other cycle.
- Throughput: minimum 2 cycles per candidate (zero-wait ack), i.e. 512 cycles per sweep.
- EV_ACK while EV_REQ=0 is ignored.
- START while BUSY is ignored.
- RST_N low mid-sweep aborts immediately: no DONE, all outputs return to reset values.
- Committed C1/C2 change only in SWEEP_END (and INIT), and are stable from DONE until the next START.

Decomposition:
- Package laser_pkg:
  - coord_t (logic [3:0]), cnt_t (logic [5:0]).
  - NUM_PTS = 40, R2 = 16.
  - INIT_C1 = (4,4), INIT_C2 = (11,11).
  - sched_state_e enum.
  - Shared with the evaluator and top.
- Sub-module laser_raster_cnt: 8-bit candidate counter with clear, step, and a last flag asserted at (15,15).

Test Plan:
- Reset: hold RST_N=0 with EV_ACK toggling -> all outputs 0, DONE never rises. Release, no START -> stays IDLE, BUSY=0.
- Evaluator always returns 5, zero-wait ack -> C1=(0,0), C2=(11,11), ROUNDS=2. DONE within 2056 cycles of START, high exactly 1 cycle.
- Evaluator returns 40 only for EV_SEL=0 at (7,3), else 10 -> C1=(7,3), C2=(11,11), ROUNDS=2.
- Same as the previous scenario with random 0-5 cycle ack delay:
  - EV_CX/EV_CY/EV_FX/EV_FY stable while EV_REQ is high.
  - Identical final result.
- Evaluator returns 2*sweep_index+1 at candidate (15,15), 0 elsewhere -> improvement every round. Stops with ROUNDS=8; C1=C2=(15,15).
- Pull RST_N low mid-sweep of round 1 -> outputs zero asynchronously. Re-START completes normally. A START pulse while BUSY has no effect on the result.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER two-circle coverage search.
// Used by the sequencing controller and the coverage evaluator.
package laser_pkg;

    localparam int NUM_PTS = 40;   // points buffered per image
    localparam int R2      = 16;   // squared coverage radius

    typedef logic [3:0] coord_t;
    typedef logic [5:0] cnt_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    // Starting centres: one in each quadrant diagonal so the first sweep
    // has a sensible partner circle to work against.
    localparam point_t INIT_C1 = '{x: 4'd4,  y: 4'd4};
    localparam point_t INIT_C2 = '{x: 4'd11, y: 4'd11};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_REQ,
        S_NEXT,
        S_SWEEP_END,
        S_FIN
    } sched_state_e;

endpackage

// File: rtl/laser_raster_cnt.sv
// Candidate-centre counter walking the grid in raster order
// (X fastest, then Y). Flags the final cell of the grid.
module laser_raster_cnt
#(
    parameter int COORD_W = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               clr,
    input  logic               step,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               last
);

    localparam int                 CW  = 2 * COORD_W;
    localparam logic [CW-1:0]      ONE = {{(CW-1){1'b0}}, 1'b1};

    // Y lives in the upper half so a plain increment gives raster order.
    logic [CW-1:0] cnt;

    // Clear has priority over step; wrap from the last cell back to (0,0).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + ONE;
        end
    end

    assign cx   = cnt[COORD_W-1:0];
    assign cy   = cnt[CW-1:COORD_W];
    assign last = &cnt;

endmodule

// File: rtl/laser_search_sched.sv
// Sequencing controller for the two-circle coverage search.
// Alternately sweeps one circle over every grid cell while the other is
// held fixed, keeps the best-scoring candidate, and stops when a full
// round (C1 sweep + C2 sweep) fails to improve or the round limit hits.
module laser_search_sched
    import laser_pkg::*;
#(
    parameter int NUM_PTS    = laser_pkg::NUM_PTS,
    parameter int COORD_W    = 4,
    parameter int CNT_W      = 6,
    parameter int MAX_ROUNDS = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    output logic               EV_REQ,
    output logic               EV_SEL,
    output logic [COORD_W-1:0] EV_CX,
    output logic [COORD_W-1:0] EV_CY,
    output logic [COORD_W-1:0] EV_FX,
    output logic [COORD_W-1:0] EV_FY,
    input  logic               EV_ACK,
    input  logic [CNT_W-1:0]   EV_CNT,
    output logic [COORD_W-1:0] C1X,
    output logic [COORD_W-1:0] C1Y,
    output logic [COORD_W-1:0] C2X,
    output logic [COORD_W-1:0] C2Y,
    output logic               DONE,
    output logic               BUSY,
    output logic [3:0]         ROUNDS
);

    // The count must be able to represent every point being covered.
    if (CNT_W < $clog2(NUM_PTS + 1)) begin : g_cnt_w_chk
        $error("CNT_W too narrow for NUM_PTS");
    end

    localparam logic [3:0] ROUND_LIM = 4'(MAX_ROUNDS);

    sched_state_e state, state_nxt;

    logic               sel;          // 0: sweeping C1, 1: sweeping C2
    logic               upd;          // shadow improved during this sweep
    logic [CNT_W-1:0]   best;
    logic [CNT_W-1:0]   round_best;   // best at the end of the previous round
    logic [COORD_W-1:0] shadow_x, shadow_y;
    logic [COORD_W-1:0] c1x, c1y, c2x, c2y;
    logic [3:0]         rounds;
    logic [3:0]         rounds_inc;

    logic               cnt_clr, cnt_step, cnt_last;
    logic [COORD_W-1:0] cand_x, cand_y;
    logic               improve;

    laser_raster_cnt #(.COORD_W(COORD_W)) u_raster (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (cnt_clr),
        .step  (cnt_step),
        .cx    (cand_x),
        .cy    (cand_y),
        .last  (cnt_last)
    );

    // Strictly greater keeps the earliest candidate on ties.
    assign improve    = (state == S_REQ) && EV_ACK && (EV_CNT > best);
    assign rounds_inc = (rounds == ROUND_LIM) ? rounds : rounds + 4'd1;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus raster counter controls.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_step  = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) state_nxt = S_INIT;
            end
            S_INIT: begin
                cnt_clr   = 1'b1;
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (EV_ACK) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                cnt_step  = 1'b1;
                state_nxt = cnt_last ? S_SWEEP_END : S_REQ;
            end
            S_SWEEP_END: begin
                cnt_clr   = 1'b1;
                state_nxt = S_REQ;
                if (sel && ((best == round_best) || (rounds_inc == ROUND_LIM)))
                    state_nxt = S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Search bookkeeping: best score, shadow candidate, committed centres.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel        <= 1'b0;
            upd        <= 1'b0;
            best       <= '0;
            round_best <= '0;
            shadow_x   <= '0;
            shadow_y   <= '0;
            c1x        <= '0;
            c1y        <= '0;
            c2x        <= '0;
            c2y        <= '0;
            rounds     <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    sel        <= 1'b0;
                    upd        <= 1'b0;
                    best       <= '0;
                    round_best <= '0;
                    shadow_x   <= '0;
                    shadow_y   <= '0;
                    rounds     <= '0;
                    c1x        <= COORD_W'(INIT_C1.x);
                    c1y        <= COORD_W'(INIT_C1.y);
                    c2x        <= COORD_W'(INIT_C2.x);
                    c2y        <= COORD_W'(INIT_C2.y);
                end
                S_REQ: begin
                    if (improve) begin
                        best     <= EV_CNT;
                        shadow_x <= cand_x;
                        shadow_y <= cand_y;
                        upd      <= 1'b1;
                    end
                end
                S_SWEEP_END: begin
                    if (upd) begin
                        if (sel) begin
                            c2x <= shadow_x;
                            c2y <= shadow_y;
                        end else begin
                            c1x <= shadow_x;
                            c1y <= shadow_y;
                        end
                    end
                    upd <= 1'b0;
                    sel <= ~sel;
                    if (sel) begin
                        rounds     <= rounds_inc;
                        round_best <= best;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign EV_REQ = (state == S_REQ);
    assign EV_SEL = sel;
    assign EV_CX  = cand_x;
    assign EV_CY  = cand_y;
    assign EV_FX  = sel ? c1x : c2x;
    assign EV_FY  = sel ? c1y : c2y;
    assign C1X    = c1x;
    assign C1Y    = c1y;
    assign C2X    = c2x;
    assign C2Y    = c2y;
    assign DONE   = (state == S_FIN);
    assign BUSY   = (state != S_IDLE);
    assign ROUNDS = rounds;

endmodule

// File: tb/tb_laser_search_sched.sv
// Directed bench for the two-circle search sequencer with a behavioural
// coverage evaluator (zero-wait or random-delay acknowledge).
module tb_laser_search_sched;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START;
    logic       EV_REQ, EV_SEL, EV_ACK;
    logic [3:0] EV_CX, EV_CY, EV_FX, EV_FY;
    logic [5:0] EV_CNT;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       DONE, BUSY;
    logic [3:0] ROUNDS;

    laser_search_sched dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .EV_REQ (EV_REQ),
        .EV_SEL (EV_SEL),
        .EV_CX  (EV_CX),
        .EV_CY  (EV_CY),
        .EV_FX  (EV_FX),
        .EV_FY  (EV_FY),
        .EV_ACK (EV_ACK),
        .EV_CNT (EV_CNT),
        .C1X    (C1X),
        .C1Y    (C1Y),
        .C2X    (C2X),
        .C2Y    (C2Y),
        .DONE   (DONE),
        .BUSY   (BUSY),
        .ROUNDS (ROUNDS)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Evaluator model controls.
    int          mode      = 0;  // 0: const 5, 1: peak at sel0 (7,3), 2: rising at (15,15)
    bit          zero_wait = 1'b0;
    bit          dly_mode  = 1'b0;
    logic        tog_ack   = 1'b0;
    logic        ack_drv   = 1'b0;
    int unsigned dly       = 0;
    bit          ev_clr    = 1'b0;
    int          eval_cnt  = 0;
    logic [5:0]  cnt_m;

    assign EV_ACK = zero_wait ? EV_REQ : (dly_mode ? ack_drv : tog_ack);
    assign EV_CNT = cnt_m;

    // Completed evaluations; eval_cnt/256 is the sweep index.
    always @(posedge CLK) begin
        if (ev_clr) eval_cnt <= 0;
        else if (EV_REQ && EV_ACK) eval_cnt <= eval_cnt + 1;
    end

    always_comb begin
        cnt_m = 6'd0;
        case (mode)
            0: cnt_m = 6'd5;
            1: cnt_m = (!EV_SEL && EV_CX == 4'd7 && EV_CY == 4'd3) ? 6'd40 : 6'd10;
            2: if (EV_CX == 4'd15 && EV_CY == 4'd15) cnt_m = 6'(2 * (eval_cnt / 256) + 1);
            default: cnt_m = 6'd0;
        endcase
    end

    // Random 0-5 cycle acknowledge delay.
    always @(negedge CLK) begin
        if (dly_mode) begin
            if (ack_drv) begin
                ack_drv = 1'b0;
                dly = $urandom_range(0, 5);
            end else if (EV_REQ) begin
                if (dly == 0) ack_drv = 1'b1;
                else dly--;
            end
        end
    end

    // Monitors: DONE-high cycle count and request-field stability.
    int          done_cnt = 0;
    int          stab_err = 0;
    bit          req_d    = 1'b0;
    logic [16:0] saved    = '0;
    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (EV_REQ && req_d && {EV_SEL, EV_CX, EV_CY, EV_FX, EV_FY} != saved) stab_err++;
        saved = {EV_SEL, EV_CX, EV_CY, EV_FX, EV_FY};
        req_d = EV_REQ;
    end

    task automatic run_case(input string tag, input int m, input bit zw, input bit dm,
                            input bit extra_start, input int ex1x, input int ex1y,
                            input int ex2x, input int ex2y, input int exr,
                            input int budget, input int max_lat);
        int k;
        bit seen;
        int d0;
        mode = m; zero_wait = zw; dly_mode = dm;
        ev_clr = 1'b1;
        @(negedge CLK);
        ev_clr = 1'b0;
        d0 = done_cnt;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        k = 1;
        seen = 1'b0;
        while (!seen && k < budget) begin
            if (DONE) begin
                seen = 1'b1;
            end else begin
                if (extra_start && k == 100) START = 1'b1;
                @(negedge CLK);
                START = 1'b0;
                k++;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency_ok"}, 32'(k <= max_lat), 32'd1);
            chk({tag, "_busy_at_done"}, 32'(BUSY), 32'd1);
            chk({tag, "_c1x"}, 32'(C1X), 32'(ex1x));
            chk({tag, "_c1y"}, 32'(C1Y), 32'(ex1y));
            chk({tag, "_c2x"}, 32'(C2X), 32'(ex2x));
            chk({tag, "_c2y"}, 32'(C2Y), 32'(ex2y));
            chk({tag, "_rounds"}, 32'(ROUNDS), 32'(exr));
            @(negedge CLK);
            chk({tag, "_done_low"}, 32'(DONE), 32'd0);
            chk({tag, "_busy_low"}, 32'(BUSY), 32'd0);
            chk({tag, "_done_width"}, 32'(done_cnt - d0), 32'd1);
            repeat (5) @(negedge CLK);
            chk({tag, "_hold_c1"}, 32'({C1X, C1Y}), 32'({4'(ex1x), 4'(ex1y)}));
            chk({tag, "_hold_c2"}, 32'({C2X, C2Y}), 32'({4'(ex2x), 4'(ex2y)}));
        end
        dly_mode = 1'b0;
        zero_wait = 1'b0;
    endtask

    initial begin
        int d0;
        int s0;
        RST_N = 1'b0;
        START = 1'b0;

        // Reset held with the acknowledge line toggling.
        d0 = done_cnt;
        repeat (6) begin
            @(negedge CLK);
            tog_ack = ~tog_ack;
        end
        chk("rst_c1", 32'({C1X, C1Y}), 32'd0);
        chk("rst_c2", 32'({C2X, C2Y}), 32'd0);
        chk("rst_ev_req", 32'(EV_REQ), 32'd0);
        chk("rst_ev_sel", 32'(EV_SEL), 32'd0);
        chk("rst_ev_cand", 32'({EV_CX, EV_CY}), 32'd0);
        chk("rst_ev_fix", 32'({EV_FX, EV_FY}), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rounds", 32'(ROUNDS), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        RST_N = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            tog_ack = ~tog_ack;
        end
        tog_ack = 1'b0;
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_req", 32'(EV_REQ), 32'd0);
        chk("idle_no_done", 32'(done_cnt - d0), 32'd0);

        // Constant score: first candidate wins C1 sweep, C2 never improves.
        run_case("const5", 0, 1'b1, 1'b0, 1'b0, 0, 0, 11, 11, 2, 2200, 2056);

        // Single peak for C1 at (7,3).
        run_case("peak", 1, 1'b1, 1'b0, 1'b0, 7, 3, 11, 11, 2, 2200, 2056);

        // Same peak with random acknowledge delay.
        s0 = stab_err;
        run_case("peak_dly", 1, 1'b0, 1'b1, 1'b0, 7, 3, 11, 11, 2, 9000, 9000);
        chk("peak_dly_req_stable", 32'(stab_err - s0), 32'd0);

        // Improvement every sweep: runs to the round limit.
        run_case("rising", 2, 1'b1, 1'b0, 1'b0, 15, 15, 15, 15, 8, 8400, 8210);

        // Abort mid-sweep with an asynchronous reset.
        mode = 1; zero_wait = 1'b1;
        ev_clr = 1'b1;
        @(negedge CLK);
        ev_clr = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (700) @(negedge CLK);
        chk("abort_pre_busy", 32'(BUSY), 32'd1);
        chk("abort_pre_c1", 32'({C1X, C1Y}), 32'({4'd7, 4'd3}));
        chk("abort_pre_sel", 32'(EV_SEL), 32'd1);
        d0 = done_cnt;
        #2 RST_N = 1'b0;
        #1;
        chk("abort_c1", 32'({C1X, C1Y}), 32'd0);
        chk("abort_c2", 32'({C2X, C2Y}), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_ev_sel", 32'(EV_SEL), 32'd0);
        chk("abort_ev_req", 32'(EV_REQ), 32'd0);
        chk("abort_ev_fix", 32'({EV_FX, EV_FY}), 32'd0);
        repeat (20) @(negedge CLK);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        zero_wait = 1'b0;
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // Restart after abort, with a stray START while busy.
        run_case("restart", 1, 1'b1, 1'b0, 1'b1, 7, 3, 11, 11, 2, 2200, 2056);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
